// File: rtl/bresenham_stream.sv
// Bresenham line rasteriser with a streaming pixel output.
// Takes one line command (two endpoints) over a valid/ready handshake and
// emits every pixel from (x0,y0) to (x1,y1) inclusive. The output stream
// supports backpressure and abort. A one-cycle done pulse publishes the
// pixel count of each completed line.
module bresenham_stream #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  // command side
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] y0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  input  logic         abort,
  // pixel stream side
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic [W-1:0] pix_x,
  output logic [W-1:0] pix_y,
  output logic         pix_last,
  // status
  output logic         busy,
  output logic         done,
  output logic [W:0]   count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  // Line parameters captured at the command handshake.
  logic [W-1:0]          end_x, end_y;
  logic [W:0]            dx;        // |x1-x0|, non-negative
  logic signed [W+1:0]   dy;        // -|y1-y0|, non-positive
  logic                  sx_neg;    // x steps downwards
  logic                  sy_neg;    // y steps downwards
  logic signed [W+1:0]   err;
  logic [W:0]            pix_cnt;

  // Combinational helpers.
  logic [W-1:0]          adx, ady;
  logic signed [W+2:0]   e2;
  logic signed [W+2:0]   dy_ext, dx_ext;
  logic                  step_x, step_y;
  logic signed [W+1:0]   add_dy, add_dx, err_next;
  logic [W-1:0]          x_next, y_next;
  logic                  handshake;

  // Absolute endpoint distances for the incoming command.
  always_comb begin
    adx = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
    ady = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
  end

  // One Bresenham step evaluated from the current error term. Both axis
  // tests use the same doubled error, so a diagonal step is a single cycle.
  // The widths leave one spare bit above the worst full-scale error so the
  // doubled term cannot overflow.
  always_comb begin
    e2       = $signed({err, 1'b0});
    dy_ext   = {dy[W+1], dy};
    dx_ext   = $signed({2'b00, dx});
    step_x   = (e2 >= dy_ext);
    step_y   = (e2 <= dx_ext);
    add_dy   = step_x ? dy : '0;
    add_dx   = step_y ? $signed({1'b0, dx}) : '0;
    err_next = err + add_dy + add_dx;
    x_next   = step_x ? (sx_neg ? pix_x - 1'b1 : pix_x + 1'b1) : pix_x;
    y_next   = step_y ? (sy_neg ? pix_y - 1'b1 : pix_y + 1'b1) : pix_y;
  end

  // Endpoint detection on the registered coordinate, gated to RUN so the
  // cleared registers in IDLE never look like an endpoint.
  assign pix_last  = (state == RUN) && (pix_x == end_x) && (pix_y == end_y);

  // Abort wins over a simultaneous transfer: that pixel is not consumed.
  assign handshake = pix_valid && pix_ready && !abort;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs.
  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    pix_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = RUN;
      end
      RUN: begin
        pix_valid = 1'b1;
        busy      = 1'b1;
        if (abort)                       state_next = IDLE;
        else if (pix_ready && pix_last)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load line parameters on a command, advance one pixel per
  // accepted transfer, and publish done/count when the endpoint goes out.
  // NOTE: all datapath flops are plain registers, not a memory, so every one
  // is cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      end_x   <= '0;
      end_y   <= '0;
      pix_x   <= '0;
      pix_y   <= '0;
      dx      <= '0;
      dy      <= '0;
      sx_neg  <= 1'b0;
      sy_neg  <= 1'b0;
      err     <= '0;
      pix_cnt <= '0;
      done    <= 1'b0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            end_x   <= x1;
            end_y   <= y1;
            pix_x   <= x0;
            pix_y   <= y0;
            dx      <= {1'b0, adx};
            dy      <= -$signed({2'b00, ady});
            sx_neg  <= !(x0 < x1);
            sy_neg  <= !(y0 < y1);
            err     <= $signed({2'b00, adx}) - $signed({2'b00, ady});
            pix_cnt <= '0;
          end
        end
        RUN: begin
          if (handshake) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_last) begin
              done  <= 1'b1;
              count <= pix_cnt + 1'b1;
            end else begin
              pix_x <= x_next;
              pix_y <= y_next;
              err   <= err_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bresenham_stream.md
Name: bresenham_stream

Overview:
Parametrised Bresenham line rasteriser; successor to the fixed 8-bit line drawer. Accepts one line command (two endpoints) over a valid/ready handshake and emits every pixel of the line as a valid/ready stream with backpressure, a last flag and a pixel count. Sits between the stroke/command decoder and the framebuffer write port.

Parameters:
W, 10, coordinate width in bits (unsigned coordinates 0..2^W-1); legal range 4..16.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command (high only in IDLE)
x0, y0  in  W  start point, sampled on command handshake
x1, y1  in  W  end point, sampled on command handshake
abort  in  1  cancel the line in progress
pix_valid  out  1  pix_x/pix_y/pix_last hold a valid pixel
pix_ready  in  1  downstream accepts pixel
pix_x, pix_y  out  W  pixel coordinate
pix_last  out  1  current pixel is the endpoint
busy  out  1  high in RUN
done  out  1  one-cycle pulse after the last pixel handshake
count  out  W+1  pixels emitted by the most recent completed line; updated with done

Behaviour:
- Reset (async): state=IDLE; cmd_ready=1; pix_valid=0, pix_last=0, busy=0, done=0; pix_x=pix_y=0; count=0; internal err/dx/dy/sx/sy=0.
- States: IDLE, RUN. Only two states; no setup cycle.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: register x1,y1; pix_x<=x0, pix_y<=y0; dx=|x1-x0| (W+1 bits unsigned); dy=-|y1-y0| (W+2 bit signed); sx=+1 if x0<x1 else -1; sy=+1 if y0<y1 else -1; err=dx+dy (W+2 bit signed); pixel counter=0; go RUN. First pix_valid appears the cycle after the command handshake (latency 1).
- RUN: pix_valid=1, busy=1, cmd_ready=0. pix_last = (pix_x==x1 && pix_y==y1), combinational on the registered coordinates.
- Outputs stable while pix_valid&&!pix_ready; no internal state advances without a pixel handshake.
- On pixel handshake (pix_valid&&pix_ready), pixel counter increments, then:
  - if pix_last: go IDLE; done=1 next cycle (exactly one cycle); count<=pixel counter+1; pix_valid drops the same cycle done rises; cmd_ready rises simultaneously.
  - else: e2=2*err (W+3 bits signed, computed from old err). If e2>=dy: x+=sx and add dy. If e2<=dx: y+=sy and add dx. Both tests use the same old e2; err_new=err+(dy if first)+(dx if second) in one cycle. Next pixel valid the following cycle; sustained throughput 1 pixel/clock with pix_ready tied high.
- Coordinates never wrap: the algorithm terminates exactly at (x1,y1); full-scale lines (0 to 2^W-1 on either axis) are legal and must not overflow err/e2.
- Pixel count for a line = max(|dx|,|dy|)+1, max 2^W, hence W+1 bits.
- Degenerate line (x0==x1, y0==y1): exactly one pixel with pix_last=1, then done.
- abort: sampled in RUN only; takes priority over a simultaneous pixel handshake (that pixel counts as not accepted). Next cycle: IDLE, pix_valid=0, done=0, count unchanged. Ignored in IDLE.
- cmd_valid while busy: ignored (cmd_ready=0); the command must be held by the sender.
- Async reset mid-line: outputs return to reset values immediately; no done pulse.

Test Plan:
- W=10, cmd (0,0)->(3,0), pix_ready=1 -> pixels (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles starting 1 cycle after handshake; pix_last only on (3,0); done pulse next cycle; count=4.
- Steep (0,0)->(2,5) -> exactly (0,0),(0,1),(1,2),(1,3),(2,4),(2,5); count=6.
- Negative direction (5,5)->(0,3) -> (5,5),(4,5),(3,4),(2,4),(1,3),(0,3); count=6.
- Single point (7,7)->(7,7) -> one pixel (7,7) with pix_last=1; done; count=1. Then full-scale (1023,0)->(0,1023) -> 1024 diagonal pixels, last (0,1023), count=1024.
- Backpressure: (0,0)->(3,0) with pix_ready toggling 1,0,0,1,0,1,1 -> same 4 pixels in order, outputs stable across stalls, no duplicates/drops, done after 4th handshake.
- Abort on 3rd pixel of (0,0)->(9,0) with pix_ready=1 -> pix_valid low next cycle, no done, count holds previous value, cmd_ready=1; new command then runs normally. Async reset asserted mid-line -> pix_valid=0, busy=0 in the same cycle, no done.
